// File: rtl/defs.sv
// Shared types and constants for the RV32I pipeline.
//   data_t        : 32-bit datapath word
//   enable_t      : single-bit control strobe
//   fetch_state_t : fetch-stage request FSM state
//   NOP_INSTR     : canonical NOP (addi x0, x0, 0)
//   PC_STEP       : sequential PC increment
package defs;

  typedef logic [31:0] data_t;
  typedef logic        enable_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_t;

  localparam data_t       NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage. Holds the PC and keeps at most one instruction
// memory request outstanding (req/gnt, then rvalid). Presents pc, pc+4 and
// the fetched instruction to IF/ID, honouring stall and redirect.
//   clk, rst                    : clock, synchronous active-high reset
//   stall_c_i                   : hold current instruction, do not advance
//   redirect_c_i, redirect_pc_i : load new PC (wins over everything but rst)
//   imem_req_o, imem_addr_o     : fetch request / address
//   imem_gnt_i                  : request accepted
//   imem_rvalid_i, imem_rdata_i : response strobe / instruction word
//   pc_o, pc_next_o             : PC of presented instruction and PC+4
//   instruction_o, valid_o      : instruction (NOP when not valid)
//   busy_o                      : !valid_o, bubble request to hazard unit
module fetch_stage
  import defs::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  enable_t     stall_c_i,
  input  enable_t     redirect_c_i,
  input  data_t       redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_next_o,
  output logic [31:0] instruction_o,
  output logic        valid_o,
  output logic        busy_o
);

  data_t        pc_q;
  data_t        instr_q;
  fetch_state_t state;
  data_t        pc_inc;
  data_t        redirect_tgt;

  assign pc_inc       = pc_q + PC_STEP;   // wraps naturally at 2^32
  assign redirect_tgt = {redirect_pc_i[31:2], 2'b00};

  // Outputs are forced to their reset values while rst is held, so the
  // interface is quiet even before the first reset edge has landed.
  always_comb begin
    imem_req_o    = 1'b0;
    valid_o       = 1'b0;
    instruction_o = NOP_INSTR;
    if (!rst && !redirect_c_i) begin
      unique case (state)
        FETCH: imem_req_o = 1'b1;
        WAIT: if (imem_rvalid_i) begin
          valid_o       = 1'b1;
          instruction_o = imem_rdata_i;
        end
        HOLD: begin
          valid_o       = 1'b1;
          instruction_o = instr_q;
        end
        default: ;
      endcase
    end
  end

  assign busy_o      = !valid_o;
  assign imem_addr_o = pc_q;
  assign pc_o        = pc_q;
  assign pc_next_o   = pc_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      state   <= FETCH;
      instr_q <= NOP_INSTR;
    end else if (redirect_c_i) begin
      pc_q <= redirect_tgt;
      // A request still in flight must have its response swallowed before
      // the target is fetched. Once DROP sees its rvalid the stale response
      // is consumed, so it may leave even under a fresh redirect.
      if ((state == WAIT || state == DROP) && !imem_rvalid_i)
        state <= DROP;
      else
        state <= FETCH;
    end else begin
      unique case (state)
        FETCH: if (imem_gnt_i) state <= WAIT;
        WAIT: if (imem_rvalid_i) begin
          if (stall_c_i) begin
            instr_q <= imem_rdata_i;
            state   <= HOLD;
          end else begin
            pc_q  <= pc_inc;
            state <= FETCH;
          end
        end
        HOLD: if (!stall_c_i) begin
          pc_q  <= pc_inc;
          state <= FETCH;
        end
        DROP: if (imem_rvalid_i) state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. The bench plays instruction memory by hand,
// one cycle at a time, and checks outputs against hand-computed values.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_c_i, redirect_c_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i, imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] pc_o, pc_next_o, instruction_o;
  logic        valid_o, busy_o;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst(rst),
    .stall_c_i(stall_c_i), .redirect_c_i(redirect_c_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .pc_o(pc_o), .pc_next_o(pc_next_o), .instruction_o(instruction_o),
    .valid_o(valid_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, then apply this cycle's inputs.
  task automatic cyc(input logic r, input logic g, input logic rv, input logic [31:0] rd,
                     input logic st, input logic re, input logic [31:0] rpc);
    @(posedge clk); #1;
    rst = r; imem_gnt_i = g; imem_rvalid_i = rv; imem_rdata_i = rd;
    stall_c_i = st; redirect_c_i = re; redirect_pc_i = rpc;
    #1;
  endtask

  initial begin
    rst = 1; imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
    stall_c_i = 0; redirect_c_i = 0; redirect_pc_i = 0;

    // reset state
    cyc(1, 1, 1, 32'h1111_1111, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("rst_req", {31'd0, imem_req_o}, 0);
    chk("rst_valid", {31'd0, valid_o}, 0);
    chk("rst_busy", {31'd0, busy_o}, 1);
    chk("rst_instr", instruction_o, NOP);
    chk("rst_pc", pc_o, 32'h100);
    chk("rst_pcnext", pc_next_o, 32'h104);

    // C1: first request, zero-wait grant
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("c1_req", {31'd0, imem_req_o}, 1);
    chk("c1_addr", imem_addr_o, 32'h100);
    chk("c1_valid", {31'd0, valid_o}, 0);
    // C2: response, passed through combinationally
    cyc(0, 0, 1, 32'h00A0_0093, 0, 0, 0);
    chk("c2_valid", {31'd0, valid_o}, 1);
    chk("c2_busy", {31'd0, busy_o}, 0);
    chk("c2_instr", instruction_o, 32'h00A0_0093);
    chk("c2_pc", pc_o, 32'h100);
    chk("c2_req", {31'd0, imem_req_o}, 0);
    // C3: next request
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("c3_addr", imem_addr_o, 32'h104);
    chk("c3_req", {31'd0, imem_req_o}, 1);

    // stall for three cycles starting at the response
    cyc(0, 0, 1, 32'h0040_0113, 1, 0, 0);
    chk("s0_valid", {31'd0, valid_o}, 1);
    chk("s0_instr", instruction_o, 32'h0040_0113);
    for (int i = 1; i < 3; i++) begin
      cyc(0, 0, 0, 32'hBAD0_0000, 1, 0, 0);
      chk("hold_valid", {31'd0, valid_o}, 1);
      chk("hold_instr", instruction_o, 32'h0040_0113);
      chk("hold_pc", pc_o, 32'h104);
      chk("hold_req", {31'd0, imem_req_o}, 0);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("unstall_instr", instruction_o, 32'h0040_0113);
    chk("unstall_pc", pc_o, 32'h104);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("post_stall_req", {31'd0, imem_req_o}, 1);
    chk("post_stall_addr", imem_addr_o, 32'h108);

    // redirect while waiting on a slow response -> drop stale data
    cyc(0, 0, 0, 0, 0, 1, 32'h0000_0203);
    chk("rd_valid", {31'd0, valid_o}, 0);
    chk("rd_req", {31'd0, imem_req_o}, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("drop_pc", pc_o, 32'h200);
    chk("drop_req", {31'd0, imem_req_o}, 0);
    cyc(0, 1, 1, 32'hDEAD_BEEF, 0, 0, 0);
    chk("drop_valid", {31'd0, valid_o}, 0);
    chk("drop_instr", instruction_o, NOP);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("tgt_req", {31'd0, imem_req_o}, 1);
    chk("tgt_addr", imem_addr_o, 32'h200);

    // rvalid and redirect in the same cycle
    cyc(0, 0, 1, 32'hCAFE_F00D, 0, 1, 32'h0000_0400);
    chk("rvrd_valid", {31'd0, valid_o}, 0);
    chk("rvrd_busy", {31'd0, busy_o}, 1);
    chk("rvrd_instr", instruction_o, NOP);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("rvrd_addr", imem_addr_o, 32'h400);
    chk("rvrd_req", {31'd0, imem_req_o}, 1);
    cyc(0, 0, 1, 32'h0000_0033, 0, 0, 0);
    chk("x400_instr", instruction_o, 32'h0000_0033);

    // PC wrap
    cyc(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFE);
    chk("wrap_rd_req", {31'd0, imem_req_o}, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
    chk("wrap_pcnext", pc_next_o, 32'h0);
    cyc(0, 0, 1, 32'h1357_9BDF, 0, 0, 0);
    chk("wrap_valid", {31'd0, valid_o}, 1);
    chk("wrap_pc", pc_o, 32'hFFFF_FFFC);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("wrap_next_addr", imem_addr_o, 32'h0);

    // reset in WAIT
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("wrst_req", {31'd0, imem_req_o}, 0);
    chk("wrst_valid", {31'd0, valid_o}, 0);
    cyc(1, 0, 1, 32'h7777_7777, 0, 0, 0);
    chk("wrst_pc", pc_o, 32'h100);
    chk("wrst_instr", instruction_o, NOP);
    chk("wrst_valid2", {31'd0, valid_o}, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("restart_req", {31'd0, imem_req_o}, 1);
    chk("restart_addr", imem_addr_o, 32'h100);

    // stall + redirect: redirect wins
    cyc(0, 0, 1, 32'h0010_0093, 1, 0, 0);
    chk("sr_hold_in", instruction_o, 32'h0010_0093);
    cyc(0, 0, 0, 0, 1, 1, 32'h0000_0080);
    chk("sr_valid", {31'd0, valid_o}, 0);
    chk("sr_instr", instruction_o, NOP);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("sr_req", {31'd0, imem_req_o}, 1);
    chk("sr_addr", imem_addr_o, 32'h80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
